// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the pio_gpio_ext peripheral: Avalon-MM word addresses
// of the register map, the edge-capture mode encoding and the ID tag returned
// from the read-only ID register.
// -----------------------------------------------------------------------------
package gpio_pkg;

    // Register map (word addresses on the 3-bit avs_address bus)
    localparam logic [2:0] GPIO_ADDR_DATA   = 3'd0;  // R: synchronised pins, W: OUT
    localparam logic [2:0] GPIO_ADDR_DIR    = 3'd1;  // R/W: 1 = output
    localparam logic [2:0] GPIO_ADDR_MASK   = 3'd2;  // R/W: interrupt enable per bit
    localparam logic [2:0] GPIO_ADDR_EDGE   = 3'd3;  // R: captured edges, W1C
    localparam logic [2:0] GPIO_ADDR_OUTSET = 3'd4;  // W1S on OUT, reads OUT
    localparam logic [2:0] GPIO_ADDR_OUTCLR = 3'd5;  // W1C on OUT, reads OUT
    localparam logic [2:0] GPIO_ADDR_OUTTGL = 3'd6;  // W1T on OUT, reads OUT
    localparam logic [2:0] GPIO_ADDR_ID     = 3'd7;  // R only

    // Which input transitions set EDGE_CAP
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    localparam logic [15:0] GPIO_ID_TAG = 16'hB0CD;

endpackage

// File: rtl/gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
// WIDTH-wide multi-flop synchroniser for asynchronous pin inputs. Every bit is
// synchronised independently; no cross-bit coherency is implied.
//
// Ports:
//   clk     - destination clock
//   rst_n   - asynchronous active-low reset, clears every stage to 0
//   pins    - asynchronous inputs
//   synced  - inputs after STAGES flops in the clk domain
// -----------------------------------------------------------------------------
module gpio_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] synced
);

    logic [STAGES-1:0][WIDTH-1:0] stage;

    // NOTE: non-blocking assignments let every stage sample the previous
    // stage's old value, which is what builds the shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= pins;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign synced = stage[STAGES-1];

endmodule

// File: rtl/pio_gpio_ext.sv
// -----------------------------------------------------------------------------
// pio_gpio_ext
// Parametrised GPIO peripheral on an Avalon-MM slave: per-bit direction,
// atomic set/clear/toggle of the output register, synchronised inputs with
// edge capture and a maskable level interrupt.
//
// Ports:
//   clk_clk        - single clock
//   reset_reset_n  - asynchronous active-low reset
//   avs_address    - word address (see gpio_pkg for the map)
//   avs_read       - read strobe, data returned one cycle later
//   avs_write      - write strobe
//   avs_writedata  - write data, bits at or above WIDTH ignored
//   avs_readdata   - registered read data, holds when no read is issued
//   irq            - level interrupt, OR of (EDGE_CAP & IRQ_MASK)
//   gpio_in        - asynchronous pin inputs
//   gpio_out       - output register
//   gpio_oe        - output enables (the direction register)
// -----------------------------------------------------------------------------
module pio_gpio_ext
    import gpio_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int               EDGE_MODE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe
);

    localparam edge_mode_e       MODE     = edge_mode_e'(EDGE_MODE);
    // Suppression counter runs 0 .. SYNC_STAGES+1 and then sticks
    localparam int               CNT_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [CNT_W-1:0] supp_cnt;

    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] edge_det;
    logic             capture_en;
    logic [31:0]      rdata_next;
    logic             unused_wdata;

    assign wdata        = avs_writedata[WIDTH-1:0];
    // Upper write-data bits have no register behind them
    assign unused_wdata = ^avs_writedata;

    // ---------------------------------------------------------------- input path
    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .pins   (gpio_in),
        .synced (sync_q)
    );

    // prev_q and sync_q are both 0 out of reset; the counter keeps capture off
    // until a pin that was already high has propagated into prev_q as well.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            prev_q   <= '0;
            supp_cnt <= '0;
        end else begin
            prev_q <= sync_q;
            if (supp_cnt != CNT_DONE) begin
                supp_cnt <= supp_cnt + CNT_W'(1);
            end
        end
    end

    assign capture_en = (supp_cnt == CNT_DONE);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        edge_det = '0;
        case (MODE)
            EDGE_RISE: edge_det = sync_q & ~prev_q;
            EDGE_FALL: edge_det = ~sync_q & prev_q;
            default:   edge_det = sync_q ^ prev_q;
        endcase
        if (!capture_en) begin
            edge_det = '0;
        end
    end

    // ------------------------------------------------------------ write decode
    always_comb begin
        out_next = out_q;
        cap_clr  = '0;
        if (avs_write) begin
            case (avs_address)
                GPIO_ADDR_DATA:   out_next = wdata;
                GPIO_ADDR_OUTSET: out_next = out_q | wdata;
                GPIO_ADDR_OUTCLR: out_next = out_q & ~wdata;
                GPIO_ADDR_OUTTGL: out_next = out_q ^ wdata;
                GPIO_ADDR_EDGE:   cap_clr  = wdata;
                default:          ;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_q  <= RESET_VALUE;
            dir_q  <= DIR_RESET;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            out_q <= out_next;
            if (avs_write && avs_address == GPIO_ADDR_DIR) begin
                dir_q <= wdata;
            end
            if (avs_write && avs_address == GPIO_ADDR_MASK) begin
                mask_q <= wdata;
            end
            // Set is applied after clear so a new edge wins over a W1C
            cap_q <= (cap_q & ~cap_clr) | edge_det;
        end
    end

    // ------------------------------------------------------------- read path
    // Muxes the current (pre-write) register values, so a read and a write to
    // the same address in one cycle returns the old contents.
    always_comb begin
        rdata_next = '0;
        case (avs_address)
            GPIO_ADDR_DATA:   rdata_next[WIDTH-1:0] = sync_q;
            GPIO_ADDR_DIR:    rdata_next[WIDTH-1:0] = dir_q;
            GPIO_ADDR_MASK:   rdata_next[WIDTH-1:0] = mask_q;
            GPIO_ADDR_EDGE:   rdata_next[WIDTH-1:0] = cap_q;
            GPIO_ADDR_OUTSET,
            GPIO_ADDR_OUTCLR,
            GPIO_ADDR_OUTTGL: rdata_next[WIDTH-1:0] = out_q;
            default:          rdata_next = {GPIO_ID_TAG, 8'h00, 8'(WIDTH)};
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rdata_next;
        end
    end

    // ----------------------------------------------------------------- outputs
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    // Straight from the registers so irq rises in the same cycle as EDGE_CAP
    assign irq      = |(cap_q & mask_q);

endmodule

// File: doc/pio_gpio_ext.md
# pio_gpio_ext

Parametrised general-purpose I/O peripheral on the FPGA-side lightweight HPS-to-FPGA Avalon-MM bus; successor to the fixed 4-bit output-only LED PIO. Provides per-bit direction control, atomic set/clear/toggle of outputs, synchronised inputs with configurable edge capture, and a maskable level interrupt to the HPS. Drives the board LEDs and BCD-display segments, and samples push-buttons and switches, from one instance type.

## Interface
- `WIDTH`, 4: number of GPIO bits, 1..32.
- `RESET_VALUE`, 0: output register value after reset.
- `DIR_RESET`, all ones: direction register after reset (1 = output).
- `EDGE_MODE`, 0: capture on 0 = rising, 1 = falling, 2 = both edges.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.

Ports:
- `clk_clk` in 1: single clock.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `avs_address` in 3: word address.
- `avs_read` in 1: read strobe.
- `avs_write` in 1: write strobe.
- `avs_writedata` in 32: write data.
- `avs_readdata` out 32: read data, valid one cycle after `avs_read`.
- `irq` out 1: level interrupt.
- `gpio_in` in WIDTH: asynchronous pin inputs.
- `gpio_out` out WIDTH: output register.
- `gpio_oe` out WIDTH: output enable, equal to the direction register.

## Operation
- **Register map, word address:**
  - 0 DATA: read returns synchronised `gpio_in`; write loads OUT.
  - 1 DIR: read/write.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read returns captured edges; writing 1 to a bit clears it.
  - 4 OUTSET: write-1 sets OUT bits.
  - 5 OUTCLR: write-1 clears OUT bits.
  - 6 OUTTGL: write-1 toggles OUT bits.
  - 7 ID: read-only, returns `{16'hB0CD, 8'h00, 8'(WIDTH)}`.
- Addresses 4–6 read back OUT. Writes to address 7 are ignored.
- Data bits at or above WIDTH are ignored on write and read as 0.
- **Input path:** `gpio_in` passes through SYNC_STAGES flops, then a delay flop `prev`.
  - Rising edge: `sync & ~prev`. Falling edge: `~sync & prev`.
  - The detected edge sets EDGE_CAP per EDGE_MODE.
- **Capture suppression after reset:** a counter counts SYNC_STAGES+1 cycles after reset deasserts. Edge capture is blocked until it saturates, so a pin already high at reset produces no false edge.
- **Priority:**
  - An edge detected in the same cycle as a write-1-clear of that bit: set wins.
  - Edge capture runs for every bit regardless of DIR.
- `irq` = OR over (EDGE_CAP & IRQ_MASK), taken directly from the registers. It has no additional flop.
- **Reset values:**
  - OUT = RESET_VALUE, DIR = DIR_RESET.
  - IRQ_MASK = 0, EDGE_CAP = 0.
  - Synchronisers and `prev` = 0, suppression counter = 0.
  - `avs_readdata` = 0, `irq` = 0.

## Timing
- **Write:** register updates at the clock edge where `avs_write` is sampled high. `gpio_out`/`gpio_oe` change at that edge.
- **Read:** `avs_readdata` is registered, so the fixed read latency is 1. It holds its last value when no read is issued.
- **Simultaneous read and write, same address:** the read returns the pre-write value.
- **Pin-to-capture latency:** SYNC_STAGES+1 rising edges from the first edge sampling the new pin level. `irq` rises in the same cycle as EDGE_CAP.
- **DATA read latency from pin:** SYNC_STAGES edges, plus 1 read-latency cycle.
- **Reset mid-operation:** all state returns to reset values asynchronously; the suppression window restarts.

## Structure
- **Package `gpio_pkg`:**
  - Address constants `GPIO_ADDR_DATA` … `GPIO_ADDR_ID`.
  - Enum `edge_mode_e` (EDGE_RISE, EDGE_FALL, EDGE_BOTH).
  - Constant `GPIO_ID_TAG = 16'hB0CD`.
- **Sub-module `gpio_sync`:** parametrised-depth, WIDTH-wide synchroniser with async active-low reset to 0. Instantiated once.

## Test plan
- **Reset defaults:** release reset with defaults -> `gpio_out` = 0, `gpio_oe` = 4'hF, `irq` = 0; read addr 7 -> 32'hB0CD0004.
- **Atomic output ops:** write DATA = 4'h5, then OUTSET 4'h2, OUTCLR 4'h1, OUTTGL 4'hC -> `gpio_out` sequence 5, 7, 6, A; each read of addr 4 one cycle later matches.
- **Rising edge and interrupt:**
  - Stimulus: IRQ_MASK = 4'h1; `gpio_in[0]` 0→1.
  - Response: EDGE_CAP = 1 and `irq` = 1 exactly 3 edges later.
  - Then write EDGE_CAP = 1 -> `irq` = 0 next cycle.
- **Set-beats-clear:** an edge on bit 2 in the same cycle as a write-1-clear of bit 2 -> EDGE_CAP[2] stays 1.
- **No false edge at reset:** hold `gpio_in` = 4'hF through reset release with EDGE_MODE = 0 -> EDGE_CAP stays 0; a later 1→0→1 on bit 3 sets only bit 3.
- **WIDTH = 32, EDGE_MODE = 2:** toggle bit 31 twice -> captured on both transitions. Write 32'hFFFF_FFFF to DIR, read back -> all ones; WIDTH = 4 instance reads back 32'h0000_000F.
